// File: rtl/conv_encoder_punct.sv
// rtl/conv_encoder_punct.sv - K=7 rate-1/2 convolutional encoder with 2/3 and 3/4 puncturing
// One data bit in per handshake, one coded bit out per clock.
module conv_encoder_punct #(
  parameter logic [6:0] GEN_A = 7'o133,
  parameter logic [6:0] GEN_B = 7'o171
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] rate_i,
  input  logic       in_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       out_o,
  output logic       out_valid_o
);

  logic [5:0] sr_q, sr_d;
  logic [1:0] phase_q, phase_d;
  logic       cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [1:0] period;
  logic [1:0] eff_phase;
  logic [1:0] phase_inc;
  logic [1:0] next_phase;
  logic       coded_a;
  logic       coded_b;
  logic       accept;

  always_comb begin
    case (rate_i)
      2'b01:   period = 2'd2;
      2'b10:   period = 2'd3;
      default: period = 2'd1;
    endcase
  end

  // A phase left over from a mid-field rate change restarts the pattern.
  assign eff_phase  = (phase_q >= period) ? 2'd0 : phase_q;
  assign phase_inc  = eff_phase + 2'd1;
  assign next_phase = (phase_inc == period) ? 2'd0 : phase_inc;

  assign coded_a = ^(GEN_A & {in_i, sr_q});
  assign coded_b = ^(GEN_B & {in_i, sr_q});

  assign in_ready_o = !cnt_q && !start_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    sr_d        = sr_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (start_i) begin
      sr_d    = '0;
      phase_d = '0;
      cnt_d   = 1'b0;
    end else if (cnt_q) begin
      out_d       = pend_q;
      out_valid_d = 1'b1;
      cnt_d       = 1'b0;
    end else if (accept) begin
      sr_d        = {in_i, sr_q[5:1]};
      phase_d     = next_phase;
      out_valid_d = 1'b1;
      if (period == 2'd3 && eff_phase == 2'd2) begin
        out_d = coded_b;
      end else if (eff_phase == 2'd1) begin
        out_d = coded_a;
      end else begin
        out_d  = coded_a;
        pend_d = coded_b;
        cnt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q        <= '0;
      phase_q     <= '0;
      cnt_q       <= 1'b0;
      pend_q      <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;

endmodule
